sram_ctrl: RTL

Memory-side controller that sits directly downstream of the MEM stage and replaces its single-cycle data memory with an external 16-bit asynchronous SRAM. Each 32-bit load or store is split into two 16-bit SRAM accesses (low half, then high half). While an access is in flight, the controller drops `ready`, and the pipeline top level ORs `~ready` into its global freeze so that every stage holds.

---
 rtl/sram_ctrl_pkg.sv | 52 +++++
 rtl/sram_ctrl_if.sv | 24 ++
 rtl/sram_wait_cnt.sv | 30 +++
 rtl/sram_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM controller.
// Optional feature macro: SRAM_CTRL_ADDR_CHECK_EN adds the range-check helper.
package sram_ctrl_pkg;

  localparam int          SRAM_AW    = 18;             // halfword address width
  localparam int          SRAM_DW    = 16;             // SRAM data width
  localparam int          WORD_W     = SRAM_AW - 1;    // 32-bit word index width
  localparam int          CNT_W      = 3;              // wait counter width (0..7)
  localparam logic [31:0] SRAM_BYTES = 32'h0008_0000;  // 2^19 bytes behind the controller

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  // One accepted MEM-stage request, frozen for the duration of the access.
  typedef struct packed {
    logic              wr;
    logic [WORD_W-1:0] word;
    logic [31:0]       wdata;
  } req_t;

  // Registered SRAM pin set.
  typedef struct packed {
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] dq_o;
    logic               dq_oe;
    logic               we_n;
    logic               oe_n;
    logic               ce_n;
  } pins_t;

  localparam pins_t PINS_IDLE = '{addr: '0, dq_o: '0, dq_oe: 1'b0,
                                  we_n: 1'b1, oe_n: 1'b1, ce_n: 1'b1};

  // Byte address to SRAM word index; bits above the SRAM wrap away.
  function automatic logic [WORD_W-1:0] word_of(input logic [31:0] address,
                                                input logic [31:0] base);
    return WORD_W'((address - base) >> 2);
  endfunction

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  // True when the byte address falls inside the SRAM window.
  function automatic logic in_range(input logic [31:0] address,
                                    input logic [31:0] base);
    return (address >= base) && ((address - base) < SRAM_BYTES);
  endfunction
`endif

endpackage

// File: rtl/sram_ctrl_if.sv
// MEM-stage side of the SRAM controller: request strobes, address/data and
// the ready (not-frozen) indication.
interface sram_ctrl_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  // The MEM stage issues requests and observes ready/read_data.
  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  // The controller consumes requests and returns ready/read_data.
  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter that times each 16-bit SRAM phase; done is high when
// the count has reached zero, i.e. on the last cycle of a phase.
module sram_wait_cnt
  import sram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Reload on phase entry, otherwise count down and rest at zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/sram_ctrl.sv
// 32-bit MEM-stage data port on top of a 16-bit asynchronous SRAM. Each
// access is split into a low-half and a high-half phase; ready drops while a
// request is outstanding so the pipeline freezes until the DONE cycle.
// Optional feature macro: SRAM_CTRL_ADDR_CHECK_EN rejects addresses outside
// the SRAM window with a one-cycle DONE and no strobe activity.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               rst,
  sram_ctrl_if.slave         mem,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_o,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n
);

  state_t      state;
  state_t      next_state;
  req_t        req_q;
  req_t        req_d;
  pins_t       pins_q;
  pins_t       pins_d;
  logic [31:0] read_data_q;
  logic        req_valid;
  logic        cnt_load;
  logic        cnt_done;
  logic        cap_lo;
  logic        cap_hi;
  logic        clr_rd;
  logic        half;

  assign req_valid = mem.rd_en | mem.wr_en;

  sram_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(WAIT_STATES)),
    .done     (cnt_done)
  );

  // State register plus the request latched on acceptance in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      req_q <= '0;
    end else begin
      state <= next_state;
      req_q <= req_d;
    end
  end

  // Next-state, counter reload and read-capture strobes.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    req_d      = req_q;
    cnt_load   = 1'b0;
    cap_lo     = 1'b0;
    cap_hi     = 1'b0;
    clr_rd     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          // A simultaneous read and write is treated as a write.
          req_d = '{wr:    mem.wr_en,
                    word:  word_of(mem.address, BASE_ADDR),
                    wdata: mem.write_data};
`ifdef SRAM_CTRL_ADDR_CHECK_EN
          if (!in_range(mem.address, BASE_ADDR)) begin
            next_state = DONE;
            clr_rd     = ~mem.wr_en;
          end else begin
            next_state = LO;
            cnt_load   = 1'b1;
          end
`else
          next_state = LO;
          cnt_load   = 1'b1;
`endif
        end
      end
      LO: begin
        if (cnt_done) begin
          next_state = HI;
          cnt_load   = 1'b1;
          cap_lo     = ~req_q.wr;
        end
      end
      HI: begin
        if (cnt_done) begin
          next_state = DONE;
          cap_hi     = ~req_q.wr;
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // SRAM pin values for the upcoming cycle, decoded from next_state so the
  // strobes come straight off flops and track the phase exactly.
  always_comb begin
    pins_d      = PINS_IDLE;
    pins_d.addr = pins_q.addr;
    pins_d.dq_o = pins_q.dq_o;
    half        = (next_state == HI);
    if ((next_state == LO) || (next_state == HI)) begin
      pins_d.addr = {req_d.word, half};
      pins_d.ce_n = 1'b0;
      if (req_d.wr) begin
        pins_d.we_n  = 1'b0;
        pins_d.dq_oe = 1'b1;
        pins_d.dq_o  = half ? req_d.wdata[31:16] : req_d.wdata[15:0];
      end else begin
        pins_d.oe_n = 1'b0;
      end
    end
  end

  // Pin register; reset parks every strobe inactive immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pins_q <= PINS_IDLE;
    end else begin
      pins_q <= pins_d;
    end
  end

  // Load result: each half captured on the last cycle of its phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data_q <= '0;
    end else if (clr_rd) begin
      read_data_q <= '0;
    end else begin
      if (cap_lo) read_data_q[15:0]  <= sram_dq_i;
      if (cap_hi) read_data_q[31:16] <= sram_dq_i;
    end
  end

  assign sram_addr  = pins_q.addr;
  assign sram_dq_o  = pins_q.dq_o;
  assign sram_dq_oe = pins_q.dq_oe;
  assign sram_we_n  = pins_q.we_n;
  assign sram_oe_n  = pins_q.oe_n;
  assign sram_ce_n  = pins_q.ce_n;

  assign mem.read_data = read_data_q;
  // With nothing requested the pipeline is never frozen.
  assign mem.ready     = ~req_valid | (state == DONE);

endmodule
